kuuga_mem_arbiter: RTL and testbench

Shares one AXI4-Lite master port between the Kuuga core's instruction-fetch and data-access request interfaces in the no-cache configuration, so that a single memory (one AXI VIP slave in simulation) can back both. Each requester uses a req/gnt/rvalid handshake. The block arbitrates round-robin, converts each granted request into exactly one AXI4-Lite read or write, and returns the response to the originator. It allows one outstanding transaction in total.

---
 rtl/kuuga_arb_pkg.sv | 24 ++
 rtl/kuuga_rr_arbiter2.sv | 38 +++
 rtl/kuuga_mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_kuuga_mem_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kuuga_arb_pkg.sv
// Shared types and constants for the Kuuga no-cache memory arbiter:
// FSM states, requester identity and AXI response decoding.
package kuuga_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } arb_state_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/kuuga_rr_arbiter2.sv
// Two-way round-robin arbiter: on a conflict, the requester not granted last wins.
// last_grant only advances when update_i marks an accepted grant.
module kuuga_rr_arbiter2
  import kuuga_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_instr_i,
  input  logic req_data_i,
  input  logic update_i,
  output logic gnt_instr_o,
  output logic gnt_data_o
);

  requester_t last_grant_q, last_grant_d;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt_instr_o  = 1'b0;
    gnt_data_o   = 1'b0;
    last_grant_d = last_grant_q;
    if (req_instr_i && req_data_i) begin
      if (last_grant_q == REQ_INSTR) gnt_data_o = 1'b1;
      else                           gnt_instr_o = 1'b1;
    end else begin
      gnt_instr_o = req_instr_i;
      gnt_data_o  = req_data_i;
    end
    if (update_i) last_grant_d = gnt_data_o ? REQ_DATA : REQ_INSTR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) last_grant_q <= REQ_INSTR;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/kuuga_mem_arbiter.sv
// Shares one AXI4-Lite master between instruction fetch and data access.
// One transaction outstanding; each grant becomes exactly one AXI read or write.
module kuuga_mem_arbiter
  import kuuga_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction fetch port
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  // data port
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [2:0]            m_axi_awprot_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,
  output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
  output logic [3:0]            m_axi_wstrb_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,
  input  logic [1:0]            m_axi_bresp_i,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [2:0]            m_axi_arprot_o,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o,
  output logic                  bus_err_o
);

  arb_state_t            state_q, state_d;
  requester_t            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  arvalid_q, arvalid_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  instr_rvalid_q, instr_rvalid_d;
  logic                  data_rvalid_q, data_rvalid_d;
  logic [DATA_WIDTH-1:0] instr_rdata_q, instr_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  bus_err_q, bus_err_d;

  logic idle;
  logic arb_gnt_instr, arb_gnt_data, arb_update;

  assign idle = (state_q == IDLE);

  kuuga_rr_arbiter2 u_rr_arbiter (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_instr_i (instr_req_i && idle),
    .req_data_i  (data_req_i && idle),
    .update_i    (arb_update),
    .gnt_instr_o (arb_gnt_instr),
    .gnt_data_o  (arb_gnt_data)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    arvalid_d      = arvalid_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    instr_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    instr_rdata_d  = instr_rdata_q;
    data_rdata_d   = data_rdata_q;
    bus_err_d      = bus_err_q;
    arb_update     = 1'b0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    m_axi_rready_o = 1'b0;
    m_axi_bready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        instr_gnt_o = arb_gnt_instr;
        data_gnt_o  = arb_gnt_data;
        if (arb_gnt_instr) begin
          arb_update = 1'b1;
          owner_d    = REQ_INSTR;
          addr_d     = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
          arvalid_d  = 1'b1;
          state_d    = RD_ADDR;
        end else if (arb_gnt_data) begin
          arb_update = 1'b1;
          owner_d    = REQ_DATA;
          addr_d     = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
          if (data_we_i) begin
            wdata_d   = data_wdata_i;
            wstrb_d   = data_be_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (m_axi_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        m_axi_rready_o = 1'b1;
        if (m_axi_rvalid_i) begin
          state_d = IDLE;
          if (owner_q == REQ_INSTR) begin
            instr_rvalid_d = 1'b1;
            instr_rdata_d  = m_axi_rdata_i;
          end else begin
            data_rvalid_d = 1'b1;
            data_rdata_d  = m_axi_rdata_i;
          end
          if (resp_is_err(m_axi_rresp_i)) bus_err_d = 1'b1;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently; leave once neither is still pending.
        if (m_axi_awready_i) awvalid_d = 1'b0;
        if (m_axi_wready_i)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_axi_bready_o = 1'b1;
        if (m_axi_bvalid_i) begin
          state_d       = IDLE;
          data_rvalid_d = 1'b1;
          data_rdata_d  = '0;
          if (resp_is_err(m_axi_bresp_i)) bus_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= REQ_INSTR;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      arvalid_q      <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      instr_rdata_q  <= '0;
      data_rdata_q   <= '0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      arvalid_q      <= arvalid_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      instr_rvalid_q <= instr_rvalid_d;
      data_rvalid_q  <= data_rvalid_d;
      instr_rdata_q  <= instr_rdata_d;
      data_rdata_q   <= data_rdata_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign instr_rvalid_o  = instr_rvalid_q;
  assign instr_rdata_o   = instr_rdata_q;
  assign data_rvalid_o   = data_rvalid_q;
  assign data_rdata_o    = data_rdata_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_kuuga_mem_arbiter.sv
// Directed bench for kuuga_mem_arbiter with a small AXI4-Lite slave model.
// Unwritten memory words read back as their word index (addr >> 2).
module tb_kuuga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic [31:0] m_axi_awaddr_o, m_axi_wdata_o, m_axi_araddr_o, m_axi_rdata_i;
  logic [2:0]  m_axi_awprot_o, m_axi_arprot_o;
  logic [3:0]  m_axi_wstrb_o;
  logic        m_axi_awvalid_o, m_axi_awready_i, m_axi_wvalid_o, m_axi_wready_i;
  logic [1:0]  m_axi_bresp_i, m_axi_rresp_i;
  logic        m_axi_bvalid_i, m_axi_bready_o, m_axi_arvalid_o, m_axi_arready_i;
  logic        m_axi_rvalid_i, m_axi_rready_o, bus_err_o;

  int tests = 0;
  int fails = 0;

  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] rresp_cfg = 2'b00;

  always #5 clk = ~clk;

  kuuga_mem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_req_i     (instr_req_i),
    .instr_gnt_o     (instr_gnt_o),
    .instr_addr_i    (instr_addr_i),
    .instr_rvalid_o  (instr_rvalid_o),
    .instr_rdata_o   (instr_rdata_o),
    .data_req_i      (data_req_i),
    .data_gnt_o      (data_gnt_o),
    .data_addr_i     (data_addr_i),
    .data_we_i       (data_we_i),
    .data_be_i       (data_be_i),
    .data_wdata_i    (data_wdata_i),
    .data_rvalid_o   (data_rvalid_o),
    .data_rdata_o    (data_rdata_o),
    .m_axi_awaddr_o  (m_axi_awaddr_o),
    .m_axi_awprot_o  (m_axi_awprot_o),
    .m_axi_awvalid_o (m_axi_awvalid_o),
    .m_axi_awready_i (m_axi_awready_i),
    .m_axi_wdata_o   (m_axi_wdata_o),
    .m_axi_wstrb_o   (m_axi_wstrb_o),
    .m_axi_wvalid_o  (m_axi_wvalid_o),
    .m_axi_wready_i  (m_axi_wready_i),
    .m_axi_bresp_i   (m_axi_bresp_i),
    .m_axi_bvalid_i  (m_axi_bvalid_i),
    .m_axi_bready_o  (m_axi_bready_o),
    .m_axi_araddr_o  (m_axi_araddr_o),
    .m_axi_arprot_o  (m_axi_arprot_o),
    .m_axi_arvalid_o (m_axi_arvalid_o),
    .m_axi_arready_i (m_axi_arready_i),
    .m_axi_rdata_i   (m_axi_rdata_i),
    .m_axi_rresp_i   (m_axi_rresp_i),
    .m_axi_rvalid_i  (m_axi_rvalid_i),
    .m_axi_rready_o  (m_axi_rready_o),
    .bus_err_o       (bus_err_o)
  );

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0] mem [0:4095];
  bit          written [0:4095];
  int          aw_cnt, w_cnt, ar_cnt, r_wait;
  logic        r_pend, aw_got, w_got;
  logic [31:0] aw_a, w_d, cap_a, cap_d;
  logic [3:0]  w_s, cap_s;
  logic        aw_hs, w_hs, ar_hs, r_hs, b_hs;

  assign m_axi_awready_i = m_axi_awvalid_o && (aw_cnt >= aw_delay);
  assign m_axi_wready_i  = m_axi_wvalid_o  && (w_cnt  >= w_delay);
  assign m_axi_arready_i = m_axi_arvalid_o && (ar_cnt >= ar_delay);
  assign aw_hs = m_axi_awvalid_o && m_axi_awready_i;
  assign w_hs  = m_axi_wvalid_o  && m_axi_wready_i;
  assign ar_hs = m_axi_arvalid_o && m_axi_arready_i;
  assign r_hs  = m_axi_rvalid_i  && m_axi_rready_o;
  assign b_hs  = m_axi_bvalid_i  && m_axi_bready_o;
  assign cap_a = aw_hs ? m_axi_awaddr_o : aw_a;
  assign cap_d = w_hs  ? m_axi_wdata_o  : w_d;
  assign cap_s = w_hs  ? m_axi_wstrb_o  : w_s;
  assign m_axi_bresp_i = 2'b00;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return written[a[13:2]] ? mem[a[13:2]] : {20'd0, a[13:2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_wait <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0;
      m_axi_rvalid_i <= 1'b0; m_axi_rdata_i <= '0; m_axi_rresp_i <= 2'b00;
      m_axi_bvalid_i <= 1'b0;
    end else begin
      aw_cnt <= (m_axi_awvalid_o && !m_axi_awready_i) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid_o  && !m_axi_wready_i)  ? w_cnt + 1  : 0;
      ar_cnt <= (m_axi_arvalid_o && !m_axi_arready_i) ? ar_cnt + 1 : 0;
      if (ar_hs) begin
        m_axi_rdata_i <= rd_word(m_axi_araddr_o);
        m_axi_rresp_i <= rresp_cfg;
        if (r_delay == 0) m_axi_rvalid_i <= 1'b1;
        else begin r_pend <= 1'b1; r_wait <= r_delay - 1; end
      end else if (r_pend) begin
        if (r_wait == 0) begin m_axi_rvalid_i <= 1'b1; r_pend <= 1'b0; end
        else r_wait <= r_wait - 1;
      end
      if (r_hs) m_axi_rvalid_i <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[cap_a[13:2]]     <= merge(rd_word(cap_a), cap_d, cap_s);
        written[cap_a[13:2]] <= 1'b1;
        m_axi_bvalid_i       <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr_o; end
        if (w_hs)  begin w_got <= 1'b1; w_d <= m_axi_wdata_o; w_s <= m_axi_wstrb_o; end
      end
      if (b_hs) m_axi_bvalid_i <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  // Zero-wait fetch: gnt in cycle 0, AR in 1, R in 2, instr_rvalid_o in 3.
  task automatic run_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_rd,
                           input logic exp_err);
    logic [31:0] exp_ar;
    exp_ar = {a[31:2], 2'b00};
    instr_req_i = 1'b1; instr_addr_i = a;
    #1;
    tests++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin
      fails++; $display("FAIL %s_gnt: got %b expected 10", tag, {instr_gnt_o, data_gnt_o});
    end
    step();
    instr_req_i = 1'b0; instr_addr_i = 32'hFFFF_FFFF;
    #1;
    tests++;
    if ({m_axi_arvalid_o, m_axi_araddr_o, m_axi_arprot_o} !== {1'b1, exp_ar, 3'b000}) begin
      fails++; $display("FAIL %s_ar: got valid=%b addr=%h prot=%b expected 1/%h/000", tag,
                        m_axi_arvalid_o, m_axi_araddr_o, m_axi_arprot_o, exp_ar);
    end
    step();
    tests++;
    if ({m_axi_rready_o, m_axi_arvalid_o, instr_rvalid_o} !== 3'b100) begin
      fails++; $display("FAIL %s_rd: got rready/arvalid/rvalid=%b expected 100", tag,
                        {m_axi_rready_o, m_axi_arvalid_o, instr_rvalid_o});
    end
    step();
    tests++;
    if ({instr_rvalid_o, instr_rdata_o, data_rvalid_o, bus_err_o} !==
        {1'b1, exp_rd, 1'b0, exp_err}) begin
      fails++; $display("FAIL %s_resp: got rvalid=%b rdata=%h drv=%b err=%b expected 1/%h/0/%b",
                        tag, instr_rvalid_o, instr_rdata_o, data_rvalid_o, bus_err_o, exp_rd, exp_err);
    end
    step();
    tests++;
    if ({instr_rvalid_o, instr_rdata_o} !== {1'b0, exp_rd}) begin
      fails++; $display("FAIL %s_hold: got rvalid=%b rdata=%h expected 0/%h", tag,
                        instr_rvalid_o, instr_rdata_o, exp_rd);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    tests++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, m_axi_awvalid_o, m_axi_wvalid_o,
         m_axi_arvalid_o, m_axi_rready_o, m_axi_bready_o, bus_err_o} !== 10'b0) begin
      fails++; $display("FAIL reset_ctrl: got nonzero control outputs expected all 0");
    end
    tests++;
    if ({instr_rdata_o, data_rdata_o, m_axi_awaddr_o, m_axi_araddr_o, m_axi_wdata_o,
         m_axi_wstrb_o} !== '0) begin
      fails++; $display("FAIL reset_data: got ird=%h drd=%h aw=%h ar=%h wd=%h expected 0",
                        instr_rdata_o, data_rdata_o, m_axi_awaddr_o, m_axi_araddr_o, m_axi_wdata_o);
    end
    apply_reset();
    step();
    tests++;
    if ({m_axi_arvalid_o, m_axi_awvalid_o, instr_rvalid_o, data_rvalid_o} !== 4'b0) begin
      fails++; $display("FAIL reset_quiet: got activity with no requests expected none");
    end
  endtask

  task automatic test_single_fetch();
    run_fetch("fetch", 32'h0000_0104, 32'h0000_0041, 1'b0);
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    int i_rv, d_rv;
    i_rv = 0; d_rv = 0;
    apply_reset();
    instr_addr_i = 32'h0000_0100;
    data_addr_i  = 32'h0000_0200;
    data_we_i    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      instr_req_i = (c <= 27);
      data_req_i  = (c <= 27);
      #1;
      exp_g = 2'b00;
      if (c <= 27 && (c % 3) == 0) exp_g = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
      tests++;
      if ({instr_gnt_o, data_gnt_o} !== exp_g) begin
        fails++; $display("FAIL contend_gnt c%0d: got %b expected %b", c,
                          {instr_gnt_o, data_gnt_o}, exp_g);
      end
      if (instr_rvalid_o) i_rv++;
      if (data_rvalid_o)  d_rv++;
      step();
    end
    tests++;
    if (i_rv != 5 || d_rv != 5) begin
      fails++; $display("FAIL contend_count: got %0d/%0d expected 5/5", i_rv, d_rv);
    end
    tests++;
    if ({instr_rdata_o, data_rdata_o} !== {32'h0000_0040, 32'h0000_0080}) begin
      fails++; $display("FAIL contend_rdata: got %h/%h expected 00000040/00000080",
                        instr_rdata_o, data_rdata_o);
    end
  endtask

  task automatic test_write();
    logic [31:0] w;
    data_req_i = 1'b1; data_addr_i = 32'h0000_2003; data_we_i = 1'b1;
    data_be_i = 4'b1000; data_wdata_i = 32'hAB00_0000;
    #1;
    tests++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      fails++; $display("FAIL wr_gnt: got %b expected 01", {instr_gnt_o, data_gnt_o});
    end
    step();
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
    #1;
    tests++;
    if ({m_axi_awvalid_o, m_axi_wvalid_o, m_axi_awaddr_o, m_axi_wstrb_o, m_axi_wdata_o,
         m_axi_awprot_o} !== {2'b11, 32'h0000_2000, 4'b1000, 32'hAB00_0000, 3'b000}) begin
      fails++; $display("FAIL wr_aw: got v=%b%b addr=%h strb=%b data=%h expected 11/2000/1000/ab000000",
                        m_axi_awvalid_o, m_axi_wvalid_o, m_axi_awaddr_o, m_axi_wstrb_o, m_axi_wdata_o);
    end
    step();
    tests++;
    if ({m_axi_bready_o, m_axi_awvalid_o, m_axi_wvalid_o} !== 3'b100) begin
      fails++; $display("FAIL wr_b: got %b expected 100",
                        {m_axi_bready_o, m_axi_awvalid_o, m_axi_wvalid_o});
    end
    step();
    tests++;
    if ({data_rvalid_o, data_rdata_o, instr_rvalid_o} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL wr_resp: got rvalid=%b rdata=%h expected 1/00000000",
                        data_rvalid_o, data_rdata_o);
    end
    step();
    w = rd_word(32'h0000_2000);
    tests++;
    if ({data_rvalid_o, w} !== {1'b0, 32'hAB00_0800}) begin
      fails++; $display("FAIL wr_mem: got rvalid=%b mem=%h expected 0/ab000800", data_rvalid_o, w);
    end
  endtask

  task automatic test_slave_delays();
    int aw_n, w_n, ar_n, r_n, rv_n, aw_c, w_c, ar_c, r_c, rv_c;
    logic        p_awv, p_wv, p_arv, p_awhs, p_whs, p_arhs;
    logic [31:0] p_awa, p_wd, p_ara;
    logic [3:0]  p_ws;
    aw_delay = 0; w_delay = 2;
    aw_n = 0; w_n = 0; rv_n = 0; aw_c = -1; w_c = -1; rv_c = -1;
    p_awv = 0; p_wv = 0; p_awhs = 0; p_whs = 0; p_awa = '0; p_wd = '0; p_ws = '0;
    for (int c = 0; c < 12; c++) begin
      data_req_i = (c == 0); data_we_i = (c == 0); data_addr_i = 32'h0000_3000;
      data_be_i = 4'hF; data_wdata_i = (c == 0) ? 32'h1234_5678 : 32'h0;
      #1;
      if (p_awv && !p_awhs) begin
        tests++;
        if ({m_axi_awvalid_o, m_axi_awaddr_o} !== {1'b1, p_awa}) begin
          fails++; $display("FAIL dly_aw_stable c%0d: got %b/%h expected 1/%h", c,
                            m_axi_awvalid_o, m_axi_awaddr_o, p_awa);
        end
      end
      if (p_wv && !p_whs) begin
        tests++;
        if ({m_axi_wvalid_o, m_axi_wdata_o, m_axi_wstrb_o} !== {1'b1, p_wd, p_ws}) begin
          fails++; $display("FAIL dly_w_stable c%0d: got %b/%h expected 1/%h", c,
                            m_axi_wvalid_o, m_axi_wdata_o, p_wd);
        end
      end
      if (aw_hs) begin aw_n++; aw_c = c; end
      if (w_hs)  begin w_n++;  w_c = c;  end
      if (data_rvalid_o) begin rv_n++; rv_c = c; end
      p_awv = m_axi_awvalid_o; p_awhs = aw_hs; p_awa = m_axi_awaddr_o;
      p_wv = m_axi_wvalid_o; p_whs = w_hs; p_wd = m_axi_wdata_o; p_ws = m_axi_wstrb_o;
      step();
    end
    tests++;
    if (aw_n != 1 || aw_c != 1 || w_n != 1 || w_c != 3 || rv_n != 1 || rv_c != 5) begin
      fails++; $display("FAIL dly_wr_timing: got aw %0d@%0d w %0d@%0d rv %0d@%0d expected 1@1 1@3 1@5",
                        aw_n, aw_c, w_n, w_c, rv_n, rv_c);
    end
    aw_delay = 0; w_delay = 0; ar_delay = 3; r_delay = 4;
    ar_n = 0; r_n = 0; rv_n = 0; ar_c = -1; r_c = -1; rv_c = -1;
    p_arv = 0; p_arhs = 0; p_ara = '0;
    for (int c = 0; c < 15; c++) begin
      data_req_i = (c == 0); data_we_i = 1'b0; data_addr_i = (c == 0) ? 32'h0000_3000 : 32'h0;
      #1;
      if (p_arv && !p_arhs) begin
        tests++;
        if ({m_axi_arvalid_o, m_axi_araddr_o} !== {1'b1, p_ara}) begin
          fails++; $display("FAIL dly_ar_stable c%0d: got %b/%h expected 1/%h", c,
                            m_axi_arvalid_o, m_axi_araddr_o, p_ara);
        end
      end
      if (ar_hs) begin ar_n++; ar_c = c; end
      if (r_hs)  begin r_n++;  r_c = c;  end
      if (data_rvalid_o) begin rv_n++; rv_c = c; end
      p_arv = m_axi_arvalid_o; p_arhs = ar_hs; p_ara = m_axi_araddr_o;
      step();
    end
    tests++;
    if (ar_n != 1 || ar_c != 4 || r_n != 1 || r_c != 9 || rv_n != 1 || rv_c != 10) begin
      fails++; $display("FAIL dly_rd_timing: got ar %0d@%0d r %0d@%0d rv %0d@%0d expected 1@4 1@9 1@10",
                        ar_n, ar_c, r_n, r_c, rv_n, rv_c);
    end
    tests++;
    if (data_rdata_o !== 32'h1234_5678) begin
      fails++; $display("FAIL dly_rdata: got %h expected 12345678", data_rdata_o);
    end
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_bus_error();
    tests++;
    if (bus_err_o !== 1'b0) begin
      fails++; $display("FAIL berr_pre: got %b expected 0", bus_err_o);
    end
    rresp_cfg = 2'b10;
    run_fetch("berr", 32'h0000_0008, 32'h0000_0002, 1'b1);
    rresp_cfg = 2'b00;
    run_fetch("berr_sticky", 32'h0000_000C, 32'h0000_0003, 1'b1);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus_err_o !== 1'b0) begin
      fails++; $display("FAIL berr_clear: got %b expected 0", bus_err_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    int rv_n;
    r_delay = 3;
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0020;
    #1;
    step();
    instr_req_i = 1'b0;
    step();
    tests++;
    if ({m_axi_rready_o, m_axi_araddr_o} !== {1'b1, 32'h0000_0020}) begin
      fails++; $display("FAIL rstmid_pre: got rready=%b araddr=%h expected 1/00000020",
                        m_axi_rready_o, m_axi_araddr_o);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, m_axi_awvalid_o, m_axi_wvalid_o,
         m_axi_arvalid_o, m_axi_rready_o, m_axi_bready_o, bus_err_o} !== 10'b0) begin
      fails++; $display("FAIL rstmid_ctrl: got nonzero control outputs expected all 0");
    end
    tests++;
    if ({instr_rdata_o, data_rdata_o, m_axi_araddr_o, m_axi_wdata_o} !== '0) begin
      fails++; $display("FAIL rstmid_data: got ird=%h drd=%h ar=%h wd=%h expected 0",
                        instr_rdata_o, data_rdata_o, m_axi_araddr_o, m_axi_wdata_o);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r_delay = 0;
    rv_n = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (instr_rvalid_o || data_rvalid_o) rv_n++;
    end
    tests++;
    if (rv_n != 0) begin
      fails++; $display("FAIL rstmid_noresp: got %0d responses expected 0", rv_n);
    end
    run_fetch("after_rst", 32'h0000_0010, 32'h0000_0004, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_write();
    test_slave_delays();
    test_bus_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
